// File: rtl/ptw_sv32_if.sv
// Request, memory, fill and response signals of the Sv32 page-table walker.
// The slave modport is the walker's view; master is the requester/memory/TLB side.
interface ptw_sv32_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_vaddr_i;
  logic        req_store_i;
  logic [21:0] satp_ppn_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        fill_req_o;
  logic [19:0] fill_vpn_o;
  logic [21:0] fill_ppn_o;
  logic [6:0]  fill_perm_o;
  logic        fill_superpage_o;
  logic        resp_valid_o;
  logic        fault_o;
  logic        flush_i;

  modport slave (
    input  req_valid_i, req_vaddr_i, req_store_i, satp_ppn_i, mem_ack_i, mem_rdata_i, flush_i,
    output req_ready_o, mem_req_o, mem_addr_o, fill_req_o, fill_vpn_o, fill_ppn_o, fill_perm_o,
           fill_superpage_o, resp_valid_o, fault_o
  );

  modport master (
    output req_valid_i, req_vaddr_i, req_store_i, satp_ppn_i, mem_ack_i, mem_rdata_i, flush_i,
    input  req_ready_o, mem_req_o, mem_addr_o, fill_req_o, fill_vpn_o, fill_ppn_o, fill_perm_o,
           fill_superpage_o, resp_valid_o, fault_o
  );
endinterface

// File: rtl/ptw_sv32.sv
// Single-walk Sv32 page-table walker feeding a TLB fill port.
// Define PTW_AD_CHECK_EN to fault leaves with A=0, or store leaves with D=0.
module ptw_sv32 (
  input logic       clk,
  input logic       rst,
  ptw_sv32_if.slave ptw_io
);
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StL1    = 3'd1;
  localparam logic [2:0] StL0    = 3'd2;
  localparam logic [2:0] StResp  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [19:0] vpn_q, vpn_d;
  logic        store_q, store_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        fault_q, fault_d;
  logic [19:0] fill_vpn_q, fill_vpn_d;
  logic [21:0] fill_ppn_q, fill_ppn_d;
  logic [6:0]  fill_perm_q, fill_perm_d;
  logic        fill_sp_q, fill_sp_d;

  logic [31:0] pte;
  logic        pte_invalid, pte_leaf, misaligned, ad_fault, resp_fire;
  logic        unused_bits;

  assign pte         = ptw_io.mem_rdata_i;
  assign pte_invalid = ~pte[0] | (~pte[1] & pte[2]);
  assign pte_leaf    = pte[1] | pte[3];
  // A level-1 leaf must map a 4 MB-aligned frame.
  assign misaligned  = (state_q == StL1) && (pte[19:10] != 10'd0);

`ifdef PTW_AD_CHECK_EN
  assign ad_fault = ~pte[6] | (store_q & ~pte[7]);
`else
  assign ad_fault = 1'b0;
`endif

  assign unused_bits = ^{ptw_io.satp_ppn_i[21:20], ptw_io.req_vaddr_i[11:0], pte[9:8], store_q};

  always_comb begin
    state_d     = state_q;
    vpn_d       = vpn_q;
    store_d     = store_q;
    mem_addr_d  = mem_addr_q;
    fault_d     = fault_q;
    fill_vpn_d  = fill_vpn_q;
    fill_ppn_d  = fill_ppn_q;
    fill_perm_d = fill_perm_q;
    fill_sp_d   = fill_sp_q;
    case (state_q)
      StIdle: begin
        if (ptw_io.req_valid_i && !ptw_io.flush_i) begin
          vpn_d      = ptw_io.req_vaddr_i[31:12];
          store_d    = ptw_io.req_store_i;
          mem_addr_d = {ptw_io.satp_ppn_i[19:0], ptw_io.req_vaddr_i[31:22], 2'b00};
          state_d    = StL1;
        end
      end
      StL1, StL0: begin
        if (ptw_io.flush_i) begin
          // An outstanding read must still complete before the bus is free again.
          state_d = ptw_io.mem_ack_i ? StIdle : StDrain;
        end else if (ptw_io.mem_ack_i) begin
          if (pte_invalid) begin
            fault_d = 1'b1;
            state_d = StResp;
          end else if (pte_leaf) begin
            fill_vpn_d  = vpn_q;
            fill_ppn_d  = pte[31:10];
            fill_perm_d = pte[7:1];
            fill_sp_d   = (state_q == StL1);
            fault_d     = misaligned | ad_fault;
            state_d     = StResp;
          end else if (state_q == StL1) begin
            mem_addr_d = {pte[29:10], vpn_q[9:0], 2'b00};
            state_d    = StL0;
          end else begin
            fault_d = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp:  state_d = StIdle;
      StDrain: if (ptw_io.mem_ack_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      vpn_q       <= '0;
      store_q     <= 1'b0;
      mem_addr_q  <= '0;
      fault_q     <= 1'b0;
      fill_vpn_q  <= '0;
      fill_ppn_q  <= '0;
      fill_perm_q <= '0;
      fill_sp_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vpn_q       <= vpn_d;
      store_q     <= store_d;
      mem_addr_q  <= mem_addr_d;
      fault_q     <= fault_d;
      fill_vpn_q  <= fill_vpn_d;
      fill_ppn_q  <= fill_ppn_d;
      fill_perm_q <= fill_perm_d;
      fill_sp_q   <= fill_sp_d;
    end
  end

  assign resp_fire               = (state_q == StResp) & ~ptw_io.flush_i;
  assign ptw_io.req_ready_o      = (state_q == StIdle) & ~ptw_io.flush_i;
  assign ptw_io.mem_req_o        = (state_q == StL1) | (state_q == StL0);
  assign ptw_io.mem_addr_o       = mem_addr_q;
  assign ptw_io.resp_valid_o     = resp_fire;
  assign ptw_io.fill_req_o       = resp_fire & ~fault_q;
  assign ptw_io.fault_o          = fault_q;
  assign ptw_io.fill_vpn_o       = fill_vpn_q;
  assign ptw_io.fill_ppn_o       = fill_ppn_q;
  assign ptw_io.fill_perm_o      = fill_perm_q;
  assign ptw_io.fill_superpage_o = fill_sp_q;
endmodule

// File: tb/tb_ptw_sv32.sv
// Scoreboard bench for ptw_sv32: directed walks, a delayed-ack memory model and a response monitor.
module tb_ptw_sv32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ptw_sv32_if bus ();
  ptw_sv32 dut (.clk(clk), .rst(rst), .ptw_io(bus));

  typedef struct {
    logic        fault;
    logic [19:0] vpn;
    logic [21:0] ppn;
    logic [6:0]  perm;
    logic        sp;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  logic [31:0] pt_mem[logic [31:0]];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          reads = 0;
  int          resp_cnt = 0;
  int          mem_dly = 0;
  bit          pending = 0;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: latches the request address, acks mem_dly cycles later even if the
  // walker has meanwhile dropped its request.
  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      if (pending && bus.mem_req_o) check("mem_addr_held", bus.mem_addr_o, pend_addr);
      if (!pending && bus.mem_req_o) begin
        pending   = 1'b1;
        cnt       = mem_dly;
        pend_addr = bus.mem_addr_o;
      end
      if (pending) begin
        if (cnt == 0) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = pt_mem.exists(pend_addr) ? pt_mem[pend_addr] : 32'h0;
          reads++;
          pending = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.resp_valid_o) begin
      resp_cnt++;
      if (expq.size() == 0) begin
        check("unexpected_resp", 32'(bus.resp_valid_o), 32'h0);
      end else begin
        mon_e = expq.pop_front();
        check("fault", 32'(bus.fault_o), 32'(mon_e.fault));
        check("fill_req", 32'(bus.fill_req_o), 32'(!mon_e.fault));
        check("latency", cyc - mon_e.acc, mon_e.lat);
        if (!mon_e.fault) begin
          check("fill_vpn", 32'(bus.fill_vpn_o), 32'(mon_e.vpn));
          check("fill_ppn", 32'(bus.fill_ppn_o), 32'(mon_e.ppn));
          check("fill_perm", 32'(bus.fill_perm_o), 32'(mon_e.perm));
          check("fill_superpage", 32'(bus.fill_superpage_o), 32'(mon_e.sp));
        end
      end
    end
  end

  // flush_after < 0: no flush; otherwise flush pulses that many cycles after acceptance.
  task automatic walk(input logic [31:0] va, input logic st, input int dly, input int flush_after,
                      input bit exp_resp, input logic exp_fault, input logic [21:0] exp_ppn,
                      input logic [6:0] exp_perm, input logic exp_sp, input int exp_lat,
                      input int exp_reads);
    exp_t e;
    int   r0, rc0;
    bit   done;
    mem_dly = dly;
    r0      = reads;
    rc0     = resp_cnt;
    @(posedge clk); #1;
    bus.req_vaddr_i = va;
    bus.req_store_i = st;
    bus.req_valid_i = 1'b1;
    if (exp_resp) begin
      e.fault = exp_fault;
      e.vpn   = va[31:12];
      e.ppn   = exp_ppn;
      e.perm  = exp_perm;
      e.sp    = exp_sp;
      e.acc   = cyc;
      e.lat   = exp_lat;
      expq.push_back(e);
    end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    if (flush_after >= 0) begin
      repeat (flush_after) begin @(posedge clk); #1; end
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) done = 1'b1;
    end
    check("walk_done", 32'(done), 32'h1);
    check("mem_reads", reads - r0, exp_reads);
    check("resp_count", resp_cnt - rc0, exp_resp ? 1 : 0);
  endtask

  localparam logic AdFault =
`ifdef PTW_AD_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    int  r0, rc0;
    bit  got;
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r0, rc0;
    bit  got;
    bus.req_valid_i = 1'b0;
    bus.req_vaddr_i = '0;
    bus.req_store_i = 1'b0;
    bus.flush_i     = 1'b0;
    bus.satp_ppn_i  = 22'h00080;
    pt_mem[32'h00080400] = 32'h00020401;
    pt_mem[32'h00081004] = 32'h048D14C7;
    pt_mem[32'h00080804] = 32'h001000CF;
    pt_mem[32'h00080C00] = 32'h001004CF;
    pt_mem[32'h00081008] = 32'h00000001;
    pt_mem[32'h0008100C] = 32'h048D1447;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready_o), 32'h1);
    check("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
    check("rst_mem_addr", bus.mem_addr_o, 32'h0);
    check("rst_resp_valid", 32'(bus.resp_valid_o), 32'h0);
    check("rst_fill_req", 32'(bus.fill_req_o), 32'h0);
    check("rst_fault", 32'(bus.fault_o), 32'h0);
    check("rst_fill_vpn", 32'(bus.fill_vpn_o), 32'h0);
    check("rst_fill_ppn", 32'(bus.fill_ppn_o), 32'h0);
    check("rst_fill_perm", 32'(bus.fill_perm_o), 32'h0);
    check("rst_fill_sp", 32'(bus.fill_superpage_o), 32'h0);

    walk(32'h40001234, 1'b0, 0, -1, 1, 1'b0, 22'h12345, 7'h63, 1'b0, 3, 2);  // 4 KB page
    walk(32'h80400000, 1'b0, 0, -1, 1, 1'b0, 22'h00400, 7'h67, 1'b1, 2, 1);  // superpage
    walk(32'hC0000000, 1'b0, 0, -1, 1, 1'b1, 22'h0, 7'h0, 1'b0, 2, 1);       // misaligned
    walk(32'h00400000, 1'b0, 0, -1, 1, 1'b1, 22'h0, 7'h0, 1'b0, 2, 1);       // V=0
    walk(32'h40002000, 1'b0, 0, -1, 1, 1'b1, 22'h0, 7'h0, 1'b0, 3, 2);       // L0 non-leaf
    walk(32'h40003000, 1'b1, 0, -1, 1, AdFault, 22'h12345, 7'h23, 1'b0, 3, 2); // store, D=0
    walk(32'h40003000, 1'b0, 0, -1, 1, 1'b0, 22'h12345, 7'h23, 1'b0, 3, 2);  // load, D=0
    walk(32'h40001234, 1'b0, 2, -1, 1, 1'b0, 22'h12345, 7'h63, 1'b0, 7, 2);  // slow memory
    walk(32'h80400000, 1'b0, 0, 1, 0, 1'b0, 22'h0, 7'h0, 1'b0, 0, 1);        // flush in RESP
    walk(32'h80400000, 1'b0, 0, 0, 0, 1'b0, 22'h0, 7'h0, 1'b0, 0, 1);        // flush with ack

    // Flush while L1 read is outstanding; ack arrives later in DRAIN.
    mem_dly = 3;
    r0  = reads;
    rc0 = resp_cnt;
    @(posedge clk); #1;
    bus.req_vaddr_i = 32'h40001234;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("drain_mem_req", 32'(bus.mem_req_o), 32'h0);
    check("drain_not_ready", 32'(bus.req_ready_o), 32'h0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk);
      if (bus.mem_ack_i) got = 1'b1;
    end
    check("drain_ack_seen", 32'(got), 32'h1);
    @(negedge clk);
    check("drain_ready_after_ack", 32'(bus.req_ready_o), 32'h1);
    check("drain_no_resp", resp_cnt - rc0, 0);
    check("drain_reads", reads - r0, 1);

    // Reset mid-walk; the late ack lands in IDLE and must be ignored.
    mem_dly = 4;
    r0  = reads;
    rc0 = resp_cnt;
    @(posedge clk); #1;
    bus.req_vaddr_i = 32'h40001234;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(bus.req_ready_o), 32'h1);
    check("midrst_mem_req", 32'(bus.mem_req_o), 32'h0);
    repeat (8) @(negedge clk);
    check("late_ack_ready", 32'(bus.req_ready_o), 32'h1);
    check("late_ack_mem_req", 32'(bus.mem_req_o), 32'h0);
    check("late_ack_no_resp", resp_cnt - rc0, 0);
    check("late_ack_reads", reads - r0, 1);

    walk(32'h80400000, 1'b0, 0, -1, 1, 1'b0, 22'h00400, 7'h67, 1'b1, 2, 1);

    check("queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
